// File: rtl/scale_factor_adap.sv
// G.726 quantizer scale-factor adaptation: MIX via a bit-serial AL multiply, then
// FUNCTW/FILTD/LIMB/FILTE update of the fast (YU) and slow (YL) scale factors.
module scale_factor_adap (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  AL,
    input  logic [1:0]  RATE,
    output logic [12:0] Y,
    output logic        y_valid,
    input  logic        i_valid,
    input  logic [4:0]  I,
    output logic        done,
    output logic [18:0] YL_out
);

    typedef enum logic [2:0] {IDLE, MUL, LOAD, WAIT_I, UPD} state_t;

    state_t      state;
    logic [2:0]  step;
    logic [6:0]  al_sh;
    logic [19:0] mcand;
    logic [19:0] acc;
    logic        difs_q;
    logic [12:0] yu;
    logic [18:0] yl;
    logic [4:0]  i_q;
    logic [1:0]  rate_q;

    logic [12:0] yl_sh;
    logic [13:0] mix_dif;
    logic [12:0] mix_difm;
    logic [13:0] prodm;
    logic [13:0] prod;
    logic [12:0] y_mix;

    logic [11:0] wi;
    logic [16:0] filtd_dif;
    logic [12:0] difsx;
    logic [12:0] yut;
    logic        gell;
    logic        geul;
    logic [12:0] yu_new;
    logic [13:0] filte_sh;
    logic [13:0] filte_dif;
    logic [18:0] yl_new;

    function automatic logic [11:0] functw(input logic [1:0] rate, input logic [4:0] code);
        logic [3:0]  im;
        logic [11:0] w;
        im = 4'd0;
        w  = 12'd0;
        case (rate)
            2'd0: begin
                im = code[4] ? ~code[3:0] : code[3:0];
                case (im)
                    4'd0:    w = 12'd14;
                    4'd1:    w = 12'd14;
                    4'd2:    w = 12'd24;
                    4'd3:    w = 12'd39;
                    4'd4:    w = 12'd40;
                    4'd5:    w = 12'd41;
                    4'd6:    w = 12'd58;
                    4'd7:    w = 12'd100;
                    4'd8:    w = 12'd141;
                    4'd9:    w = 12'd179;
                    4'd10:   w = 12'd219;
                    4'd11:   w = 12'd280;
                    4'd12:   w = 12'd358;
                    4'd13:   w = 12'd440;
                    4'd14:   w = 12'd529;
                    4'd15:   w = 12'd696;
                    default: w = 12'd0;
                endcase
            end
            2'd1: begin
                im = {1'b0, (code[3] ? ~code[2:0] : code[2:0])};
                case (im)
                    4'd0:    w = 12'd4084;
                    4'd1:    w = 12'd18;
                    4'd2:    w = 12'd41;
                    4'd3:    w = 12'd64;
                    4'd4:    w = 12'd112;
                    4'd5:    w = 12'd198;
                    4'd6:    w = 12'd355;
                    4'd7:    w = 12'd1122;
                    default: w = 12'd0;
                endcase
            end
            2'd2: begin
                im = {2'b00, (code[2] ? ~code[1:0] : code[1:0])};
                case (im)
                    4'd0:    w = 12'd4092;
                    4'd1:    w = 12'd30;
                    4'd2:    w = 12'd137;
                    4'd3:    w = 12'd582;
                    default: w = 12'd0;
                endcase
            end
            default: begin
                im = {3'b000, (code[1] ? ~code[0] : code[0])};
                w  = (im == 4'd0) ? 12'd4074 : 12'd439;
            end
        endcase
        return w;
    endfunction

    // MIX: sign/magnitude split of YU - YL/64, recombined with the serial product
    assign yl_sh    = yl[18:6];
    assign mix_dif  = {1'b0, yu} - {1'b0, yl_sh};
    assign mix_difm = mix_dif[13] ? 13'(14'd0 - mix_dif) : mix_dif[12:0];
    assign prodm    = 14'(acc >> 6);
    assign prod     = difs_q ? (14'd0 - prodm) : prodm;
    assign y_mix    = 13'({1'b0, yl_sh} + prod);

    // FILTD / LIMB / FILTE; GEUL set means YUT is still below the 5120 ceiling
    assign wi        = functw(rate_q, i_q);
    assign filtd_dif = {wi, 5'd0} - {4'd0, Y};
    assign difsx     = {filtd_dif[16], 12'(filtd_dif >> 5)};
    assign yut       = Y + difsx;
    assign gell      = 1'(({1'b0, yut} + 14'd15840) >> 13);
    assign geul      = 1'(({1'b0, yut} + 14'd11264) >> 13);
    assign yu_new    = gell ? 13'd544 : (geul ? yut : 13'd5120);
    assign filte_sh  = 14'((20'd0 - {1'b0, yl}) >> 6);
    assign filte_dif = {1'b0, yu_new} + filte_sh;
    assign yl_new    = yl + {{5{filte_dif[13]}}, filte_dif};

    // Sample sequencer; MUL step 0 snapshots the MIX operand, steps 1..7 consume AL LSB first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            step    <= 3'd0;
            al_sh   <= 7'd0;
            mcand   <= 20'd0;
            acc     <= 20'd0;
            difs_q  <= 1'b0;
            yu      <= 13'd544;
            yl      <= 19'd34816;
            i_q     <= 5'd0;
            rate_q  <= 2'd0;
            Y       <= 13'd544;
            y_valid <= 1'b0;
            done    <= 1'b0;
            YL_out  <= 19'd34816;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        al_sh <= AL;
                        step  <= 3'd0;
                        state <= MUL;
                    end
                end
                MUL: begin
                    if (step == 3'd0) begin
                        mcand  <= {7'd0, mix_difm};
                        difs_q <= mix_dif[13];
                        acc    <= 20'd0;
                    end else begin
                        if (al_sh[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand <= mcand << 1;
                        al_sh <= {1'b0, al_sh[6:1]};
                    end
                    step <= step + 3'd1;
                    if (step == 3'd7) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    Y       <= y_mix;
                    y_valid <= 1'b1;
                    state   <= WAIT_I;
                end
                WAIT_I: begin
                    if (i_valid) begin
                        i_q    <= I;
                        rate_q <= RATE;
                        state  <= UPD;
                    end
                end
                UPD: begin
                    yu      <= yu_new;
                    yl      <= yl_new;
                    YL_out  <= yl_new;
                    done    <= 1'b1;
                    y_valid <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scale_factor_adap.sv
// Randomized self-checking bench for scale_factor_adap against an integer-arithmetic
// model of the G.726 scale-factor recursion.
module tb_scale_factor_adap;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [6:0]  AL;
    logic [1:0]  RATE;
    logic [12:0] Y;
    logic        y_valid;
    logic        i_valid;
    logic [4:0]  I;
    logic        done;
    logic [18:0] YL_out;

    int n_cmp = 0;
    int n_bad = 0;
    int m_yu;
    int m_yl;

    localparam int W40 [16] = '{14, 14, 24, 39, 40, 41, 58, 100, 141, 179, 219, 280, 358, 440, 529, 696};
    localparam int W32 [8]  = '{-12, 18, 41, 64, 112, 198, 355, 1122};
    localparam int W24 [4]  = '{-4, 30, 137, 582};
    localparam int W16 [2]  = '{-22, 439};

    always #5 clk = ~clk;

    scale_factor_adap dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .AL      (AL),
        .RATE    (RATE),
        .Y       (Y),
        .y_valid (y_valid),
        .i_valid (i_valid),
        .I       (I),
        .done    (done),
        .YL_out  (YL_out)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic int wrap(input int v, input int m);
        return ((v % m) + m) % m;
    endfunction

    // Y = YL/64 + AL/64 * (YU - YL/64), product magnitude truncated
    function automatic int model_y(input int al);
        int ysh, d, p;
        ysh = m_yl / 64;
        d   = m_yu - ysh;
        p   = (d < 0) ? -(((-d) * al) / 64) : (d * al) / 64;
        return wrap(ysh + p, 8192);
    endfunction

    function automatic int model_wi(input int rate, input int code);
        int bits, v, im;
        bits = 5 - rate;
        v    = code % (1 << bits);
        im   = (v >= (1 << (bits - 1))) ? ((1 << bits) - 1 - v) : v;
        case (rate)
            0:       return W40[im];
            1:       return W32[im];
            2:       return W24[im];
            default: return W16[im];
        endcase
    endfunction

    task automatic model_update(input int y, input int rate, input int code);
        int wi, yut;
        wi   = model_wi(rate, code);
        yut  = wrap(y + ((wi * 32 - y) >>> 5), 8192);
        m_yu = (yut < 544) ? 544 : ((yut >= 5120) ? 5120 : yut);
        m_yl = wrap(m_yl + m_yu + ((-m_yl) >>> 6), 524288);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_yu  = 544;
        m_yl  = 34816;
    endtask

    task automatic do_sample(input int al, input int rate, input int code, input bit stray);
        int  n;
        int  exp_y;
        bit  seen;
        exp_y   = model_y(al);
        AL      = 7'(al);
        start   = 1'b1;
        i_valid = stray;
        I       = 5'($urandom);
        RATE    = 2'($urandom);
        tick();
        start = 1'b0;
        AL    = 7'($urandom_range(127, 0));
        seen  = 1'b0;
        n     = 0;
        while (!seen && n < 20) begin
            if (stray && n <= 6) begin
                i_valid = 1'($urandom_range(1, 0));
                I       = 5'($urandom);
                RATE    = 2'($urandom);
            end else begin
                i_valid = 1'b0;
            end
            tick();
            n++;
            seen = y_valid;
        end
        i_valid = 1'b0;
        check("y_latency", n, 9);
        if (!seen) return;
        check("y_value", int'(Y), exp_y);
        if (stray) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            check("wait_start_ignored", int'(y_valid), 1);
            check("wait_y_hold", int'(Y), exp_y);
        end
        i_valid = 1'b1;
        I       = 5'(code);
        RATE    = 2'(rate);
        start   = stray;
        tick();
        i_valid = 1'b0;
        start   = 1'b0;
        I       = 5'($urandom);
        RATE    = 2'($urandom);
        check("done_early", int'(done), 0);
        model_update(exp_y, rate, code);
        tick();
        check("done_pulse", int'(done), 1);
        check("y_valid_drop", int'(y_valid), 0);
        check("yl_update", int'(YL_out), m_yl);
        tick();
        check("done_single", int'(done), 0);
    endtask

    initial begin
        int al_tab [3];
        int y_tab  [3];
        int prev;
        al_tab = '{0, 32, 64};
        y_tab  = '{561, 1105, 1649};
        reset   = 1'b1;
        start   = 1'b0;
        i_valid = 1'b0;
        AL      = 7'd0;
        RATE    = 2'd0;
        I       = 5'd0;
        tick();
        check("rst_y", int'(Y), 544);
        check("rst_yl", int'(YL_out), 34816);
        check("rst_y_valid", int'(y_valid), 0);
        check("rst_done", int'(done), 0);
        reset = 1'b0;
        m_yu  = 544;
        m_yl  = 34816;

        do_sample(0, 1, 0, 1'b0);
        check("i0_y", int'(Y), 544);
        check("i0_yl_hold", int'(YL_out), 34816);

        for (int k = 0; k < 3; k++) begin
            apply_reset();
            do_sample(0, 1, 7, 1'b0);
            check("i7_yl", int'(YL_out), 35921);
            do_sample(al_tab[k], 1, 7, 1'b0);
            check("i7_next_y", int'(Y), y_tab[k]);
        end

        // stray i_valid in IDLE must leave the state untouched
        i_valid = 1'b1;
        I       = 5'd7;
        RATE    = 2'd1;
        tick();
        tick();
        i_valid = 1'b0;
        check("idle_ivalid_yv", int'(y_valid), 0);
        check("idle_ivalid_done", int'(done), 0);
        check("idle_ivalid_yl", int'(YL_out), m_yl);

        apply_reset();
        prev = 0;
        for (int j = 0; j < 12; j++) begin
            do_sample(64, 1, 7, 1'b0);
            check("sat_monotonic", int'(int'(Y) < prev), 0);
            check("sat_ceiling", int'(int'(Y) > 5120), 0);
            prev = int'(Y);
        end
        check("sat_value", int'(Y), 5120);

        apply_reset();
        for (int j = 0; j < 150; j++) begin
            do_sample($urandom_range(64, 0), $urandom_range(3, 0), $urandom_range(31, 0),
                      1'($urandom_range(1, 0)));
        end

        // reset in the middle of MUL abandons the sample
        AL    = 7'd64;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_y", int'(Y), 544);
        check("mid_rst_yl", int'(YL_out), 34816);
        check("mid_rst_y_valid", int'(y_valid), 0);
        check("mid_rst_done", int'(done), 0);
        tick();
        check("mid_rst_no_done", int'(done), 0);
        reset = 1'b0;
        m_yu  = 544;
        m_yl  = 34816;
        do_sample(32, 1, 7, 1'b0);
        do_sample(48, 3, 1, 1'b1);
        do_sample(20, 0, 31, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
